// File: rtl/fx_bus_pkg.sv
// fx_bus_pkg: shared definitions for the fx register bus.
//   - command opcodes carried on the USB byte stream
//   - address field widths ({dev_id, register})
//   - state encoding of the command bridge FSM
package fx_bus_pkg;

  localparam logic [7:0] FX_OP_WR = 8'h57;
  localparam logic [7:0] FX_OP_RD = 8'h52;

  localparam int unsigned FX_DEV_W  = 6;
  localparam int unsigned FX_REG_W  = 16;
  localparam int unsigned FX_ADDR_W = FX_DEV_W + FX_REG_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADR2,
    ST_ADR1,
    ST_ADR0,
    ST_DATA,
    ST_WSTB,
    ST_RSTB,
    ST_RWAIT,
    ST_RESP
  } fx_state_e;

  function automatic logic fx_is_op(input logic [7:0] b);
    return (b == FX_OP_WR) || (b == FX_OP_RD);
  endfunction

endpackage

// File: rtl/fx_rx_timeout.sv
// fx_rx_timeout: inter-byte idle counter for packet reception.
//   clk_sys  in   system clock
//   rst      in   synchronous active-high reset
//   run      in   counting enabled (packet partially received)
//   clr      in   a byte was accepted this cycle; restart the count
//   expired  out  high in the cycle that completes TIMEOUT_CYC idle cycles
module fx_rx_timeout #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYC);

  logic [16:0] cnt;
  logic [16:0] cnt_inc;

  assign cnt_inc = cnt + 17'd1;
  // The limit is reached at the end of this cycle if no byte arrives in it.
  assign expired = run && !clr && (cnt_inc == LIMIT);

  always_ff @(posedge clk_sys) begin
    if (rst || !run || clr) begin
      cnt <= '0;
    end else if (cnt_inc != LIMIT) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/fx_cmd_bridge.sv
// fx_cmd_bridge: master of the fx register bus driven by a command byte stream.
//   clk_sys, rst           clock, synchronous active-high reset
//   rx_data/valid/ready    command byte stream (57 A2 A1 A0 D | 52 A2 A1 A0)
//   tx_data/valid/ready    one response byte per read command
//   fx_waddr/fx_wr/fx_data write strobe with address and data
//   fx_raddr/fx_rd         read strobe with address
//   fx_q                   OR-combined slave read data, RD_LAT cycles after fx_rd
//   busy                   FSM not idle
//   pkt_err                one-cycle pulse on bad opcode or inter-byte timeout
module fx_cmd_bridge
  import fx_bus_pkg::*;
#(
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [FX_ADDR_W-1:0] fx_waddr,
  output logic                 fx_wr,
  output logic [7:0]           fx_data,
  output logic [FX_ADDR_W-1:0] fx_raddr,
  output logic                 fx_rd,
  input  logic [7:0]           fx_q,
  output logic                 busy,
  output logic                 pkt_err
);

  localparam int unsigned LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

  fx_state_e            state_q, state_d;
  logic                 accept;
  logic                 bad_op;
  logic                 expired;
  logic                 rx_phase;
  logic                 op_wr_q;
  logic [FX_ADDR_W-1:0] addr_sh;
  logic [FX_ADDR_W-1:0] addr_q;
  logic [LAT_W-1:0]     lat_cnt;
  logic                 lat_done;

  assign accept   = rx_valid && rx_ready;
  assign rx_phase = state_q inside {ST_ADR2, ST_ADR1, ST_ADR0, ST_DATA};
  assign lat_done = (lat_cnt == LAT_W'(RD_LAT - 1));

  // Incoming address bytes collect in addr_sh; the visible address register
  // only changes when a strobe is issued, so aborted packets leave it intact.
  assign fx_waddr = addr_q;
  assign fx_raddr = addr_q;

  fx_rx_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_sys(clk_sys),
    .rst    (rst),
    .run    (rx_phase),
    .clr    (accept),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fx_is_op(rx_data)) state_d = ST_ADR2;
          else                   bad_op  = 1'b1;
        end
      end
      ST_ADR2: begin
        if (accept)       state_d = ST_ADR1;
        else if (expired) state_d = ST_IDLE;
      end
      ST_ADR1: begin
        if (accept)       state_d = ST_ADR0;
        else if (expired) state_d = ST_IDLE;
      end
      ST_ADR0: begin
        if (accept)       state_d = op_wr_q ? ST_DATA : ST_RSTB;
        else if (expired) state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (accept)       state_d = ST_WSTB;
        else if (expired) state_d = ST_IDLE;
      end
      ST_WSTB:  state_d = ST_IDLE;
      ST_RSTB:  state_d = ST_RWAIT;
      ST_RWAIT: if (lat_done) state_d = ST_RESP;
      ST_RESP:  if (tx_valid && tx_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      fx_wr    <= 1'b0;
      fx_rd    <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      pkt_err  <= 1'b0;
      op_wr_q  <= 1'b0;
      addr_sh  <= '0;
      addr_q   <= '0;
      fx_data  <= '0;
      lat_cnt  <= '0;
    end else begin
      state_q <= state_d;

      // Outputs are decoded from the next state so each is registered.
      rx_ready <= state_d inside {ST_IDLE, ST_ADR2, ST_ADR1, ST_ADR0, ST_DATA};
      busy     <= (state_d != ST_IDLE);
      fx_wr    <= (state_d == ST_WSTB);
      fx_rd    <= (state_d == ST_RSTB);
      tx_valid <= (state_d == ST_RESP);
      pkt_err  <= bad_op || expired;

      if (accept) begin
        case (state_q)
          ST_IDLE: op_wr_q <= (rx_data == FX_OP_WR);
          ST_ADR2: addr_sh[FX_ADDR_W-1:FX_REG_W] <= rx_data[FX_DEV_W-1:0];
          ST_ADR1: addr_sh[FX_REG_W-1:8] <= rx_data;
          ST_ADR0: begin
            addr_sh[7:0] <= rx_data;
            if (!op_wr_q) addr_q <= {addr_sh[FX_ADDR_W-1:8], rx_data};
          end
          ST_DATA: begin
            addr_q  <= addr_sh;
            fx_data <= rx_data;
          end
          default: ;
        endcase
      end

      if (state_q == ST_RWAIT) lat_cnt <= lat_cnt + LAT_W'(1);
      else                     lat_cnt <= '0;

      if (state_q == ST_RWAIT && lat_done) tx_data <= fx_q;
    end
  end

endmodule

// File: tb/tb_fx_cmd_bridge.sv
module tb_fx_cmd_bridge;

  localparam int unsigned RD_LAT = 1;
  localparam int unsigned TMO    = 20;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic [21:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q;
  logic        busy;
  logic        pkt_err;

  always #5 clk_sys = ~clk_sys;

  fx_cmd_bridge #(
    .RD_LAT     (RD_LAT),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .fx_waddr(fx_waddr),
    .fx_wr   (fx_wr),
    .fx_data (fx_data),
    .fx_raddr(fx_raddr),
    .fx_rd   (fx_rd),
    .fx_q    (fx_q),
    .busy    (busy),
    .pkt_err (pkt_err)
  );

  // Slave population: registered read data, one cycle after fx_rd.
  function automatic logic [7:0] slave_val(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
  endfunction

  initial fx_q = 8'h00;
  always @(posedge clk_sys) fx_q <= fx_rd ? slave_val(fx_raddr) : 8'h00;

  // tx_ready: 0 = always ready, 1 = random, 2 = held low
  int tx_mode = 0;
  always @(negedge clk_sys) begin
    if (tx_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    else              tx_ready = (tx_mode == 0);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Observed bus/stream events.
  logic [29:0] wr_log[$];
  logic [21:0] rd_log[$];
  logic [7:0]  tx_log[$];
  int          err_cnt = 0;

  // Behavioural model: packet parser over the accepted bytes plus a read
  // countdown; expected outputs for the cycle following each edge.
  logic        m_rx_ready, m_fx_wr, m_fx_rd, m_pkt_err, m_tx_valid, m_busy;
  logic [7:0]  m_tx_data, m_data;
  logic [21:0] m_addr;
  logic [7:0]  m_pkt[$];
  int          m_quiet;
  int          m_rd_wait;
  logic        m_acc;
  int          m_need;

  task automatic model_step();
    if (rst) begin
      m_rx_ready = 0; m_fx_wr = 0; m_fx_rd = 0; m_pkt_err = 0;
      m_tx_valid = 0; m_busy = 0; m_tx_data = 0; m_data = 0; m_addr = 0;
      m_pkt.delete(); m_quiet = 0; m_rd_wait = 0;
    end else begin
      m_fx_wr = 0; m_fx_rd = 0; m_pkt_err = 0;
      if (m_rd_wait > 0) begin
        m_rd_wait--;
        if (m_rd_wait == 0) begin
          m_tx_valid = 1;
          m_tx_data  = slave_val(m_addr);
        end
      end else if (m_tx_valid) begin
        if (tx_ready) begin
          m_tx_valid = 0;
          m_rx_ready = 1;
        end
      end else begin
        m_acc      = rx_valid && m_rx_ready;
        m_rx_ready = 1;
        if (m_acc) begin
          m_quiet = 0;
          if (m_pkt.size() == 0) begin
            if (rx_data == 8'h57 || rx_data == 8'h52) m_pkt.push_back(rx_data);
            else m_pkt_err = 1;
          end else begin
            m_pkt.push_back(rx_data);
            m_need = (m_pkt[0] == 8'h57) ? 5 : 4;
            if (m_pkt.size() == m_need) begin
              m_addr = {m_pkt[1][5:0], m_pkt[2], m_pkt[3]};
              if (m_need == 5) begin
                m_data  = m_pkt[4];
                m_fx_wr = 1;
              end else begin
                m_fx_rd   = 1;
                m_rd_wait = RD_LAT + 1;
              end
              m_rx_ready = 0;
              m_pkt.delete();
            end
          end
        end else if (m_pkt.size() > 0) begin
          m_quiet++;
          if (m_quiet == TMO) begin
            m_pkt_err = 1;
            m_pkt.delete();
            m_quiet = 0;
          end
        end
      end
      m_busy = (m_pkt.size() > 0) || !m_rx_ready;
    end
  endtask

  task automatic run_checker();
    forever begin
      @(posedge clk_sys);
      if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_log.push_back(tx_data);
      model_step();
      #2;
      chk("rx_ready", rx_ready, m_rx_ready);
      chk("busy", busy, m_busy);
      chk("fx_wr", fx_wr, m_fx_wr);
      chk("fx_rd", fx_rd, m_fx_rd);
      chk("pkt_err", pkt_err, m_pkt_err);
      chk("tx_valid", tx_valid, m_tx_valid);
      chk("tx_data", tx_data, m_tx_data);
      chk("fx_waddr", fx_waddr, m_addr);
      chk("fx_raddr", fx_raddr, m_addr);
      chk("fx_data", fx_data, m_data);
      if (fx_wr === 1'b1) wr_log.push_back({fx_waddr, fx_data});
      if (fx_rd === 1'b1) rd_log.push_back(fx_raddr);
      if (pkt_err === 1'b1) err_cnt++;
    end
  endtask

  function automatic logic [29:0] last_wr();
    return (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : 30'h0;
  endfunction
  function automatic logic [21:0] last_rd();
    return (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : 22'h0;
  endfunction
  function automatic logic [7:0] last_tx();
    return (tx_log.size() > 0) ? tx_log[tx_log.size()-1] : 8'h00;
  endfunction

  task automatic send_pkt(input logic [7:0] b[$], input int gap_max);
    int g;
    int n;
    foreach (b[i]) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (g > 0) begin
        rx_valid = 1'b0;
        repeat (g) @(negedge clk_sys);
      end
      rx_valid = 1'b1;
      rx_data  = b[i];
      n = 0;
      forever begin
        @(posedge clk_sys);
        n++;
        if (rx_ready === 1'b1) break;
        if (n >= 300) begin
          chk("rx_accept_bound", 0, 1);
          break;
        end
      end
      @(negedge clk_sys);
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_tx_valid(input int bound);
    int n = 0;
    while (tx_valid !== 1'b1 && n < bound) begin
      @(negedge clk_sys);
      n++;
    end
    chk("tx_valid_rise", tx_valid, 1);
  endtask

  task automatic wait_tx_count(input int target, input int bound);
    int n = 0;
    while (tx_log.size() < target && n < bound) begin
      @(negedge clk_sys);
      n++;
    end
    chk("tx_count", tx_log.size(), target);
  endtask

  task automatic main_seq();
    logic [7:0] pk[$];
    int wr0, rd0, tx0, er0, r, keep;
    logic [7:0] op, bb;

    repeat (3) @(negedge clk_sys);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_waddr", fx_waddr, 0);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("post_rst_rx_ready", rx_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Single write.
    wr0 = wr_log.size(); rd0 = rd_log.size(); tx0 = tx_log.size();
    pk = {8'h57, 8'h01, 8'h00, 8'h81, 8'hA5};
    send_pkt(pk, 0);
    idle(4);
    chk("wr_count", wr_log.size() - wr0, 1);
    chk("wr_value", last_wr(), {22'h010081, 8'hA5});
    chk("wr_no_rd", rd_log.size() - rd0, 0);
    chk("wr_no_tx", tx_log.size() - tx0, 0);

    // Read with a stalled consumer.
    tx_mode = 2;
    rd0 = rd_log.size(); tx0 = tx_log.size();
    pk = {8'h52, 8'h01, 8'h00, 8'h00};
    send_pkt(pk, 0);
    wait_tx_valid(20);
    repeat (5) @(negedge clk_sys);
    chk("rd_hold_valid", tx_valid, 1);
    chk("rd_hold_no_xfer", tx_log.size() - tx0, 0);
    tx_mode = 0;
    wait_tx_count(tx0 + 1, 20);
    idle(3);
    chk("rd_count", rd_log.size() - rd0, 1);
    chk("rd_addr", last_rd(), 22'h010000);
    chk("rd_resp", last_tx(), 8'h01);
    chk("rd_one_xfer", tx_log.size() - tx0, 1);

    // Bad opcode then a write.
    er0 = err_cnt; wr0 = wr_log.size();
    pk = {8'h33};
    send_pkt(pk, 0);
    pk = {8'h57, 8'h02, 8'h00, 8'h80, 8'h11};
    send_pkt(pk, 0);
    idle(4);
    chk("badop_err", err_cnt - er0, 1);
    chk("badop_wr", last_wr(), {22'h020080, 8'h11});
    chk("badop_wr_count", wr_log.size() - wr0, 1);

    // Timeout mid-packet, then a read.
    er0 = err_cnt; rd0 = rd_log.size(); tx0 = tx_log.size();
    pk = {8'h52, 8'h01};
    send_pkt(pk, 0);
    idle(TMO + 3);
    chk("tmo_err", err_cnt - er0, 1);
    chk("tmo_no_rd", rd_log.size() - rd0, 0);
    pk = {8'h52, 8'h01, 8'h00, 8'h80};
    send_pkt(pk, 0);
    wait_tx_count(tx0 + 1, 20);
    chk("tmo_rd_addr", last_rd(), 22'h010080);
    chk("tmo_rd_resp", last_tx(), 8'h81);

    // Reset while a response is pending.
    tx_mode = 2;
    tx0 = tx_log.size();
    pk = {8'h52, 8'h03, 8'h12, 8'h34};
    send_pkt(pk, 0);
    wait_tx_valid(20);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("rstresp_tx_valid", tx_valid, 0);
    chk("rstresp_rx_ready", rx_ready, 0);
    chk("rstresp_busy", busy, 0);
    chk("rstresp_raddr", fx_raddr, 0);
    chk("rstresp_tx_data", tx_data, 0);
    rst = 1'b0;
    tx_mode = 0;
    idle(5);
    chk("rstresp_no_xfer", tx_log.size() - tx0, 0);

    // Reset while in the middle of an address.
    rd0 = rd_log.size(); wr0 = wr_log.size();
    pk = {8'h52, 8'h01};
    send_pkt(pk, 0);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("rstadr_busy", busy, 0);
    rst = 1'b0;
    idle(6);
    chk("rstadr_no_rd", rd_log.size() - rd0, 0);
    pk = {8'h57, 8'h00, 8'h00, 8'h05, 8'h7E};
    send_pkt(pk, 0);
    idle(3);
    chk("rstadr_wr", last_wr(), {22'h000005, 8'h7E});
    chk("rstadr_wr_count", wr_log.size() - wr0, 1);

    // Back-to-back reads with rx_valid held high.
    tx0 = tx_log.size(); rd0 = rd_log.size();
    pk = {8'h52, 8'h0A, 8'h11, 8'h22, 8'h52, 8'h3F, 8'hFF, 8'h00,
          8'h52, 8'hC5, 8'h01, 8'h02};
    send_pkt(pk, 0);
    wait_tx_count(tx0 + 3, 40);
    chk("b2b_rd_count", rd_log.size() - rd0, 3);
    chk("b2b_addr0", rd_log[rd0],     22'h0A1122);
    chk("b2b_addr1", rd_log[rd0 + 1], 22'h3FFF00);
    chk("b2b_addr2", rd_log[rd0 + 2], 22'h050102);
    chk("b2b_resp0", tx_log[tx0],     8'h39);
    chk("b2b_resp1", tx_log[tx0 + 1], 8'hC0);
    chk("b2b_resp2", tx_log[tx0 + 2], 8'h06);

    // Randomized traffic, checked by the model every cycle.
    tx_mode = 1;
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      pk.delete();
      if (r == 0) begin
        bb = 8'($urandom);
        if (bb == 8'h57 || bb == 8'h52) bb = 8'h00;
        pk.push_back(bb);
        send_pkt(pk, 2);
      end else begin
        op = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
        pk = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
        if (op == 8'h57) pk.push_back(8'($urandom));
        if (r == 1) begin
          keep = $urandom_range(1, pk.size() - 1);
          while (pk.size() > keep) void'(pk.pop_back());
          send_pkt(pk, 2);
          idle(TMO + $urandom_range(0, 3));
        end else begin
          send_pkt(pk, 2);
        end
      end
    end
    tx_mode = 0;
    idle(30);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    fork
      run_checker();
      main_seq();
      begin
        #500000;
        chk("watchdog", 0, 1);
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
